// File: rtl/nap_timer_pkg.sv
// Shared types and constants for the nap timer: FSM encoding, keypad codes,
// and the digit range check used by the keypad shift buffer.
package nap_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MANUAL = 3'd1,
    ST_READY  = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DONE   = 3'd4
  } nap_state_e;

  localparam logic [3:0] KEY_CONFIRM = 4'hA;
  localparam logic [5:0] SEC_MAX     = 6'd59;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/nap_timer_if.sv
// Controller <-> nap timer signal bundle. The controller (master) drives the
// one-hot enables and keypad strobe; the timer (slave) returns status and mm:ss.
interface nap_timer_if;
  import nap_timer_pkg::*;

  // keyValid is a one-cycle strobe with no back-pressure: keyCode is sampled
  // on every edge where keyValid is high and the timer always accepts it.
  logic       init;
  logic       enAutoSetting;
  logic       enManualSetting;
  logic       enSleep;
  logic       enCancel;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       completeSetting;
  logic       completeSleep;
  logic [6:0] remainMin;
  logic [5:0] remainSec;
  nap_state_e state;

  modport master (
    output init, enAutoSetting, enManualSetting, enSleep, enCancel, keyValid, keyCode,
    input  completeSetting, completeSleep, remainMin, remainSec, state
  );

  modport slave (
    input  init, enAutoSetting, enManualSetting, enSleep, enCancel, keyValid, keyCode,
    output completeSetting, completeSleep, remainMin, remainSec, state
  );
endinterface

// File: rtl/nap_timer_sec_prescaler.sv
// One-second tick generator: counts enabled cycles 0..CLK_FREQ-1 and pulses
// tick combinationally on the terminal cycle. Freezes while enable is low.
module nap_timer_sec_prescaler #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == TERM);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/nap_timer.sv
// Nap timer responder: latches an auto or keypad-entered duration, counts it
// down in mm:ss while the controller is in sleep, and flags expiry.
module nap_timer
  import nap_timer_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int AUTO_MIN = 20
) (
  input  logic        clock,
  input  logic        reset,
  nap_timer_if.slave  nap
);

  nap_state_e state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       setting_q;
  logic       sleep_done_q;

  logic       clr;
  logic       tick;
  logic [6:0] entry_val;

  assign clr       = nap.init | nap.enCancel;
  assign entry_val = 7'(tens_q) * 7'd10 + 7'(ones_q);

  // The prescaler is held at zero outside COUNT so every nap starts on a fresh second.
  nap_timer_sec_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clr || (state_q != ST_COUNT)),
    .enable ((state_q == ST_COUNT) && nap.enSleep),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    if (clr) begin
      state_d = ST_IDLE;
      min_d   = '0;
      sec_d   = '0;
      tens_d  = '0;
      ones_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_MANUAL: begin
          if (nap.enAutoSetting) begin
            state_d = ST_READY;
            min_d   = 7'(AUTO_MIN);
            sec_d   = '0;
          end else if (state_q == ST_IDLE) begin
            if (nap.enManualSetting) begin
              state_d = ST_MANUAL;
              tens_d  = '0;
              ones_d  = '0;
            end
          end else if (nap.keyValid) begin
            if (is_digit(nap.keyCode)) begin
              tens_d = ones_q;
              ones_d = nap.keyCode;
            end else if (nap.keyCode == KEY_CONFIRM && entry_val != 7'd0) begin
              state_d = ST_READY;
              min_d   = entry_val;
              sec_d   = '0;
            end
          end
        end
        ST_READY: begin
          if (nap.enSleep) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (tick) begin
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
              if (min_q == 7'd0 && sec_q == 6'd1) state_d = ST_DONE;
            end else begin
              sec_d = SEC_MAX;
              min_d = min_q - 7'd1;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      min_q        <= '0;
      sec_q        <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      setting_q    <= 1'b0;
      sleep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      setting_q    <= (state_d == ST_READY);
      sleep_done_q <= (state_d == ST_DONE);
    end
  end

  assign nap.completeSetting = setting_q;
  assign nap.completeSleep   = sleep_done_q;
  assign nap.remainMin       = min_q;
  assign nap.remainSec       = sec_q;
  assign nap.state           = state_q;

endmodule

// File: tb/tb_nap_timer.sv
// Bench for nap_timer: directed scenarios plus random traffic, checked against
// a seconds-remaining reference model with a keypad digit queue.
module tb_nap_timer;
  import nap_timer_pkg::*;

  localparam int CLK  = 4;
  localparam int AUTO = 20;
  localparam int P_IDLE = 0, P_ENTRY = 1, P_LOADED = 2, P_RUN = 3, P_EXPIRED = 4;

  logic clock = 1'b0;
  logic reset;
  nap_timer_if nif();

  nap_timer #(.CLK_FREQ(CLK), .AUTO_MIN(AUTO)) dut (
    .clock (clock),
    .reset (reset),
    .nap   (nif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  int m_phase;
  int m_rem;
  int m_digits[$];
  int m_pre;
  logic [14:0] exp_q[$];

  logic [14:0] obs;
  assign obs = {nif.completeSetting, nif.completeSleep, nif.remainMin, nif.remainSec};

  function automatic logic [14:0] exp_vec();
    return {m_phase == P_LOADED, m_phase == P_EXPIRED, 7'(m_rem / 60), 6'(m_rem % 60)};
  endfunction

  task automatic model_update();
    int v;
    if (reset || nif.init || nif.enCancel) begin
      m_phase = P_IDLE; m_rem = 0; m_digits.delete(); m_pre = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (nif.enAutoSetting) begin m_rem = AUTO * 60; m_phase = P_LOADED; end
          else if (nif.enManualSetting) begin m_phase = P_ENTRY; m_digits.delete(); end
        end
        P_ENTRY: begin
          if (nif.enAutoSetting) begin m_rem = AUTO * 60; m_phase = P_LOADED; end
          else if (nif.keyValid) begin
            if (nif.keyCode <= 4'd9) begin
              m_digits.push_back(int'(nif.keyCode));
              if (m_digits.size() > 2) void'(m_digits.pop_front());
            end else if (nif.keyCode == 4'hA) begin
              if (m_digits.size() == 2) v = m_digits[0] * 10 + m_digits[1];
              else if (m_digits.size() == 1) v = m_digits[0];
              else v = 0;
              if (v != 0) begin m_rem = v * 60; m_phase = P_LOADED; end
            end
          end
        end
        P_LOADED: if (nif.enSleep) begin m_phase = P_RUN; m_pre = 0; end
        P_RUN: begin
          if (nif.enSleep) begin
            m_pre++;
            if (m_pre == CLK) begin
              m_pre = 0;
              m_rem--;
              if (m_rem == 0) m_phase = P_EXPIRED;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  // driver tasks: inputs change on the falling edge, model advances with the DUT
  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic drive_quiet();
    nif.init = 0; nif.enAutoSetting = 0; nif.enManualSetting = 0;
    nif.enSleep = 0; nif.enCancel = 0; nif.keyValid = 0; nif.keyCode = 4'h0;
  endtask

  task automatic press(input logic [3:0] k);
    nif.keyValid = 1; nif.keyCode = k; step();
    nif.keyValid = 0; nif.keyCode = 4'h0;
  endtask

  task automatic pulse_init();
    nif.init = 1; step(); nif.init = 0;
  endtask

  task automatic pulse_manual();
    nif.enManualSetting = 1; step(); nif.enManualSetting = 0;
  endtask

  task automatic load_one_minute();
    pulse_init(); pulse_manual(); press(4'd0); press(4'd1); press(4'hA);
  endtask

  task automatic test_reset();
    reset = 1; drive_quiet(); step(); step();
    n_checks++;
    if (obs !== 15'd0) $display("FAIL reset_outputs: got %h want %h", obs, 15'd0);
    else n_pass++;
    n_checks++;
    if (nif.state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", nif.state, ST_IDLE);
    else n_pass++;
    reset = 0; step();
  endtask

  task automatic test_auto();
    nif.enAutoSetting = 1; step(); nif.enAutoSetting = 0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 7'd20, 6'd0}) $display("FAIL auto_load: got %h want %h", obs, {1'b1, 1'b0, 7'd20, 6'd0});
    else n_pass++;
    pulse_init();
    n_checks++;
    if (obs !== 15'd0) $display("FAIL init_clears: got %h want %h", obs, 15'd0);
    else n_pass++;
  endtask

  task automatic test_manual();
    pulse_manual(); press(4'd4); press(4'd5); press(4'hA);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 7'd45, 6'd0}) $display("FAIL manual_45: got %h want %h", obs, {1'b1, 1'b0, 7'd45, 6'd0});
    else n_pass++;
    pulse_init(); pulse_manual(); press(4'd1); press(4'd2); press(4'd3); press(4'hA);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 7'd23, 6'd0}) $display("FAIL manual_23: got %h want %h", obs, {1'b1, 1'b0, 7'd23, 6'd0});
    else n_pass++;
    pulse_init(); pulse_manual(); press(4'd0); press(4'hA);
    n_checks++;
    if (obs !== 15'd0 || nif.state !== ST_MANUAL)
      $display("FAIL manual_zero: got %h state %0d want %h state %0d", obs, nif.state, 15'd0, ST_MANUAL);
    else n_pass++;
    press(4'd7); nif.enAutoSetting = 1; step(); nif.enAutoSetting = 0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 7'd20, 6'd0}) $display("FAIL manual_flip_auto: got %h want %h", obs, {1'b1, 1'b0, 7'd20, 6'd0});
    else n_pass++;
    pulse_init();
  endtask

  task automatic test_manual_random();
    logic [14:0] e;
    for (int it = 0; it < 10; it++) begin
      pulse_init(); pulse_manual();
      for (int d = 0; d < int'($urandom_range(1, 4)); d++) begin
        if ($urandom_range(0, 3) == 0) press(4'($urandom_range(11, 15)));
        press(4'($urandom_range(0, 9)));
      end
      press(4'hA);
      exp_q.push_back(exp_vec());
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL manual_random_%0d: got %h want %h", it, obs, e);
      else n_pass++;
    end
    pulse_init();
  endtask

  task automatic test_countdown();
    int n;
    load_one_minute();
    nif.enSleep = 1; n = 0;
    while (n < 300 && nif.completeSleep !== 1'b1) begin
      step(); n++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL countdown_cycle_%0d: got %h want %h", n, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (n !== 241) $display("FAIL countdown_length: got %0d edges want %0d", n, 241);
    else n_pass++;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 7'd0, 6'd0}) $display("FAIL countdown_done: got %h want %h", obs, {1'b0, 1'b1, 7'd0, 6'd0});
    else n_pass++;
    nif.enSleep = 0; step(); pulse_init();
  endtask

  task automatic test_freeze();
    int n;
    int hold;
    load_one_minute();
    nif.enSleep = 1; n = 0;
    while (n < 400 && !(nif.remainMin == 7'd0 && nif.remainSec == 6'd30)) begin step(); n++; end
    n_checks++;
    if (n >= 400) $display("FAIL freeze_reach_30: got timeout after %0d cycles want 00:30", n);
    else n_pass++;
    nif.enSleep = 0;
    hold = $urandom_range(15, 25);
    for (int i = 0; i < hold; i++) begin
      step();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 7'd0, 6'd30}) $display("FAIL freeze_hold_%0d: got %h want %h", i, obs, {1'b0, 1'b0, 7'd0, 6'd30});
      else n_pass++;
    end
    nif.enSleep = 1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (obs !== {1'b0, 1'b0, 7'd0, 6'd29}) $display("FAIL freeze_resume: got %h want %h", obs, {1'b0, 1'b0, 7'd0, 6'd29});
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL freeze_after_%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    nif.enSleep = 0; pulse_init();
  endtask

  task automatic test_cancel();
    int n;
    load_one_minute();
    nif.enSleep = 1; n = 0;
    while (n < 400 && !(nif.remainMin == 7'd0 && nif.remainSec == 6'd10)) begin step(); n++; end
    n_checks++;
    if (n >= 400) $display("FAIL cancel_reach_10: got timeout after %0d cycles want 00:10", n);
    else n_pass++;
    nif.enCancel = 1; step(); nif.enCancel = 0; nif.enSleep = 0;
    n_checks++;
    if (obs !== 15'd0 || nif.state !== ST_IDLE)
      $display("FAIL cancel_clears: got %h state %0d want %h state %0d", obs, nif.state, 15'd0, ST_IDLE);
    else n_pass++;
    press(4'd5); press(4'hA); step();
    n_checks++;
    if (obs !== 15'd0) $display("FAIL idle_keys_ignored: got %h want %h", obs, 15'd0);
    else n_pass++;
  endtask

  task automatic test_done_reset();
    int n;
    load_one_minute();
    nif.enSleep = 1; n = 0;
    while (n < 300 && nif.completeSleep !== 1'b1) begin step(); n++; end
    n_checks++;
    if (nif.completeSleep !== 1'b1) $display("FAIL done_reached: got %b want 1", nif.completeSleep);
    else n_pass++;
    reset = 1; step(); reset = 0; nif.enSleep = 0;
    n_checks++;
    if (obs !== 15'd0) $display("FAIL reset_in_done: got %h want %h", obs, 15'd0);
    else n_pass++;
    nif.enAutoSetting = 1; nif.enManualSetting = 1; step();
    nif.enAutoSetting = 0; nif.enManualSetting = 0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 7'd20, 6'd0} || nif.state !== ST_READY)
      $display("FAIL auto_beats_manual: got %h want %h", obs, {1'b1, 1'b0, 7'd20, 6'd0});
    else n_pass++;
    pulse_init();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      nif.init            = (r < 2);
      nif.enCancel        = (r >= 2 && r < 4);
      nif.enAutoSetting   = ($urandom_range(0, 99) < 4);
      nif.enManualSetting = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 6) nif.enSleep = ~nif.enSleep;
      nif.keyValid = ($urandom_range(0, 99) < 30);
      nif.keyCode  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random_cycle_%0d: got %h want %h", i, obs, exp_vec());
      else n_pass++;
    end
    drive_quiet(); pulse_init();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; drive_quiet();
    m_phase = P_IDLE; m_rem = 0; m_pre = 0;
    @(negedge clock);
    test_reset();
    test_auto();
    test_manual();
    test_manual_random();
    test_countdown();
    test_freeze();
    test_cancel();
    test_done_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
